// File: rtl/ucode_store_arbiter.sv
// ucode_store_arbiter: fixed-priority arbiter for the single-port micro-code store
// with speculative-fetch starvation override and a flushable tagged read-response stage.
module ucode_store_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_pipeline,
    input  logic              norm_req,
    input  logic [ADDR_W-1:0] norm_addr,
    output logic              norm_gnt,
    output logic              norm_valid,
    output logic [DATA_W-1:0] norm_data,
    input  logic              spec_req,
    input  logic [ADDR_W-1:0] spec_addr,
    output logic              spec_gnt,
    output logic              spec_valid,
    output logic [DATA_W-1:0] spec_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_NORM, TAG_SPEC} tag_t;
    localparam logic [1:0] SMAX = 2'(STARVE_MAX);
    logic       blk, s_eff, s_force;
    logic [1:0] starve_cnt;
    tag_t       tag;
    always_comb begin
        blk       = rst || flush_pipeline;
        s_eff     = spec_req && (spec_addr != '1);
        s_force   = s_eff && (starve_cnt == SMAX);
        ld_gnt    = !blk && ld_req;
        spec_gnt  = !blk && !ld_req && s_eff && (s_force || !norm_req);
        norm_gnt  = !blk && !ld_req && norm_req && !s_force;
        mem_en    = ld_gnt || spec_gnt || norm_gnt;
        mem_we    = ld_gnt;
        mem_addr  = ld_gnt ? ld_addr : spec_gnt ? spec_addr : norm_gnt ? norm_addr : '1;
        mem_wdata = ld_gnt ? ld_wdata : '0;
    end
    // The tag marks a read issued last cycle; a flush now squashes its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            tag        <= TAG_NONE;
            norm_valid <= 1'b0;
            spec_valid <= 1'b0;
            norm_data  <= '0;
            spec_data  <= '0;
        end else begin
            starve_cnt <= (flush_pipeline || !s_eff || spec_gnt) ? 2'd0 :
                          (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 2'd1;
            tag        <= spec_gnt ? TAG_SPEC : norm_gnt ? TAG_NORM : TAG_NONE;
            norm_valid <= !flush_pipeline && (tag == TAG_NORM);
            spec_valid <= !flush_pipeline && (tag == TAG_SPEC);
            if (!flush_pipeline && tag == TAG_NORM) norm_data <= mem_rdata;
            if (!flush_pipeline && tag == TAG_SPEC) spec_data <= mem_rdata;
        end
    end
endmodule

// File: doc/ucode_store_arbiter.md
# ucode_store_arbiter

Shares the single-port synchronous micro-code store between three requesters: the control unit's normal micro-code fetch, its speculative micro-code fetch, and the micro-code loader that writes the store. Issues at most one store access per cycle under a fixed priority, with a starvation override for speculative fetch. Returns read data to the winning requester through a registered, tagged response stage that pipeline flushes can squash. Sits between the control unit's two micro-code address ports and the micro-code RAM.

## Interface
- ADDR_W, 8, micro-code address width
- DATA_W, 32, micro-code word width
- STARVE_MAX, 3, consecutive speculative denials before override (1..3)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- flush_pipeline  in  1  squash all in-flight reads and starvation history
- norm_req  in  1  normal fetch request
- norm_addr  in  ADDR_W  normal fetch address
- norm_gnt  out  1  normal request accepted this cycle (combinational)
- norm_valid  out  1  normal read data valid (registered)
- norm_data  out  DATA_W  normal read data (registered, held between responses)
- spec_req  in  1  speculative fetch request
- spec_addr  in  ADDR_W  speculative address; all-ones = idle
- spec_gnt / spec_valid / spec_data  out  1/1/DATA_W  as normal port
- ld_req  in  1  loader write request
- ld_addr / ld_wdata  in  ADDR_W/DATA_W  write address/data
- ld_gnt  out  1  write accepted this cycle
- mem_en / mem_we  out  1/1  store enable / write enable (combinational)
- mem_addr / mem_wdata  out  ADDR_W/DATA_W  store address / write data
- mem_rdata  in  DATA_W  store read data, one cycle after mem_en with mem_we=0

## Operation
- Effective requests: L = ld_req; N = norm_req; S = spec_req and spec_addr != all-ones.
- No grants while rst or flush_pipeline is high.
- Priority, per cycle, exactly one grant or none: L wins if present; else S wins if present and starve_cnt == STARVE_MAX; else N; else S.
- Grant drives mem_en=1, mem_addr from winner; mem_we=1 and mem_wdata=ld_wdata only for L. No grant: mem_en=0, mem_we=0, mem_addr=all-ones, mem_wdata=0.
- A write blocks all reads that cycle; the store is read-first, so a read granted the following cycle returns the new word. No bypass inside the arbiter.
- starve_cnt (2-bit): cleared by rst, flush, S granted, or S absent; incremented (saturating at STARVE_MAX) when S is present and not granted, including denial by L.
- Response pipeline: stage-1 tag register (none/norm/spec) captures the read winner at grant cycle T. In T+1, mem_rdata is registered into norm_data or spec_data per tag and the matching valid is set; outputs visible in T+2.
- Flush in T or T+1 clears the tag/valid for that read; the data register is not updated.
- Reset values: norm_valid=0, spec_valid=0, norm_data=0, spec_data=0, tag=none, starve_cnt=0. Combinational outputs follow the no-grant values during reset.

## Timing
- Request-to-grant: 0 cycles (same cycle, combinational).
- Grant-to-valid: 2 cycles (grant in T, valid high for exactly one cycle in T+2).
- Throughput: one access per cycle; back-to-back reads pipeline fully.
- Writes: retire in grant cycle, no response.
- Requester holds req and address until its gnt; the arbiter does not queue.
- Simultaneous flush and grant-worthy requests: no grant; starve_cnt=0 next cycle.
- Reset asserted mid-read: response discarded, no valid after reset release.

## Test plan
- Reset: rst=1 for 2 cycles with all reqs high -> no gnt, mem_en=0, mem_addr=8'hFF; after release all valids 0, data 0.
- Normal read: norm_req=1, norm_addr=8'h10 in T, mem_rdata=32'hA5A5_0010 in T+1 -> norm_gnt=1 in T, norm_valid=1 and norm_data=32'hA5A5_0010 in T+2 only.
- Priority and starvation: N and S (spec_addr=8'h20) held continuously, STARVE_MAX=3 -> grants N,N,N,S,N,N,N,S...; starve_cnt returns to 0 after each S grant.
- Loader: ld_req with ld_addr=8'h30, ld_wdata=32'hDEAD_BEEF, plus N to 8'h30 -> T: ld_gnt, mem_we=1; T+1: norm_gnt; T+3: norm_data=32'hDEAD_BEEF.
- Idle speculative: spec_req=1, spec_addr=8'hFF, nothing else -> no spec_gnt, mem_en=0, starve_cnt stays 0.
- Flush: spec read granted in T (8'h40), flush_pipeline=1 in T+1 -> spec_valid stays 0 in T+2, spec_data unchanged; requests during flush cycle get no gnt.
